// File: rtl/pvs_pkg.sv
// Shared constants, FSM state encoding and vector word layout for pattern_vector_sequencer.
// Vector word layout, MSB to LSB: {wft, wfc, rpt, last}.
package pvs_pkg;

    localparam int unsigned PVS_NUM_SIG = 23;
    localparam int unsigned PVS_WFC_W   = 8;
    localparam int unsigned PVS_WFT_W   = 4;
    localparam int unsigned PVS_DEPTH   = 4;
    localparam int unsigned PVS_RPT_W   = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHigh,
        StLow,
        StStall
    } pvs_state_e;

    function automatic int unsigned vec_word_width(int unsigned wft_w, int unsigned wfc_bits);
        return wft_w + wfc_bits + PVS_RPT_W + 1;
    endfunction

endpackage

// File: rtl/pattern_vector_sequencer_if.sv
// Vector-loader handshake into the sequencer: master = loader, slave = sequencer.
interface pattern_vector_sequencer_if #(
    parameter int unsigned WFT_W    = 4,
    parameter int unsigned WFC_BITS = 184
);
    logic                vec_valid;
    logic                vec_ready;
    logic [WFT_W-1:0]    vec_wft;
    logic [0:WFC_BITS-1] vec_wfc;
    logic [15:0]         vec_rpt;
    logic                vec_last;

    modport master (
        output vec_valid, vec_wft, vec_wfc, vec_rpt, vec_last,
        input  vec_ready
    );

    modport slave (
        input  vec_valid, vec_wft, vec_wfc, vec_rpt, vec_last,
        output vec_ready
    );
endinterface

// File: rtl/pvs_vec_fifo.sv
// Synchronous vector FIFO with first-word-fall-through head and registered ready (not full).
module pvs_vec_fifo #(
    parameter int unsigned WIDTH = 205,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             ready
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q, count_d;
    logic             ready_q, do_push, do_pop;

    assign do_push = push && ready_q;
    assign do_pop  = pop && (count_q != '0);
    assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            count_q <= count_d;
            // Ready looks one push ahead so it never admits a word into a full FIFO.
            ready_q <= (count_d != (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

    assign head  = mem_q[rd_q];
    assign empty = (count_q == '0);
    assign ready = ready_q;
endmodule

// File: rtl/pattern_vector_sequencer.sv
// Tester-cycle source: buffers vectors and drives tester_sync/wft/wfc with programmable widths.
// Optional PVS_SIGNATURE_EN adds a 16-bit running signature of emitted vectors.
module pattern_vector_sequencer
    import pvs_pkg::*;
#(
    parameter int unsigned NUM_SIG = PVS_NUM_SIG,
    parameter int unsigned WFC_W   = PVS_WFC_W,
    parameter int unsigned WFT_W   = PVS_WFT_W,
    parameter int unsigned DEPTH   = PVS_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic [7:0]                 hi_cyc,
    input  logic [7:0]                 lo_cyc,
    pattern_vector_sequencer_if.slave  vec,
    output logic                       tester_sync,
    output logic [WFT_W-1:0]           wft,
    output logic [0:NUM_SIG*WFC_W-1]   wfc,
    output logic                       busy,
    output logic                       done,
    output logic                       underrun,
`ifdef PVS_SIGNATURE_EN
    output logic [15:0]                signature,
`endif
    output logic [31:0]                vec_count
);
    localparam int unsigned WfcBits = NUM_SIG * WFC_W;
    localparam int unsigned VecW    = vec_word_width(WFT_W, WfcBits);

    logic [VecW-1:0]      push_word, head_word;
    logic                 fifo_empty, fifo_ready, pop;
    logic [WFT_W-1:0]     head_wft;
    logic [0:WfcBits-1]   head_wfc;
    logic [PVS_RPT_W-1:0] head_rpt;
    logic                 head_last;

    pvs_state_e           state_q;
    logic [7:0]           cnt_q, hi_q, lo_q, hi_eff, lo_eff;
    logic [PVS_RPT_W-1:0] rpt_q;
    logic                 last_q, stop_q, sync_q, done_q, underrun_q;
    logic [WFT_W-1:0]     wft_q;
    logic [0:WfcBits-1]   wfc_q;
    logic [31:0]          count_q;
    logic                 stop_req, enter_high;

    assign push_word = {vec.vec_wft, vec.vec_wfc, vec.vec_rpt, vec.vec_last};
    assign {head_wft, head_wfc, head_rpt, head_last} = head_word;
    assign vec.vec_ready = fifo_ready;

    // Outputs are loaded from the FIFO head on entry to LOAD; the pop itself happens in LOAD.
    assign pop = (state_q == StLoad);

    pvs_vec_fifo #(
        .WIDTH (VecW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vec.vec_valid),
        .push_data (push_word),
        .pop       (pop),
        .head      (head_word),
        .empty     (fifo_empty),
        .ready     (fifo_ready)
    );

    assign hi_eff     = (hi_cyc == '0) ? 8'd1 : hi_cyc;
    assign lo_eff     = (lo_cyc == '0) ? 8'd1 : lo_cyc;
    assign stop_req   = stop_q || stop;
    assign enter_high = (state_q == StLoad) ||
                        ((state_q == StLow) && (cnt_q == '0) && (rpt_q != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            hi_q       <= 8'd1;
            lo_q       <= 8'd1;
            rpt_q      <= '0;
            last_q     <= 1'b0;
            stop_q     <= 1'b0;
            sync_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            wft_q      <= '0;
            wfc_q      <= '0;
            count_q    <= '0;
        end else begin
            if (stop) stop_q <= 1'b1;
            if (enter_high) begin
                sync_q  <= 1'b1;
                count_q <= count_q + 32'd1;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        done_q     <= 1'b0;
                        underrun_q <= 1'b0;
                        count_q    <= '0;
                        stop_q     <= 1'b0;
                        state_q    <= fifo_empty ? StStall : StLoad;
                        if (!fifo_empty) begin
                            wft_q  <= head_wft;
                            wfc_q  <= head_wfc;
                            rpt_q  <= head_rpt;
                            last_q <= head_last;
                        end
                    end
                end
                StLoad: begin
                    hi_q    <= hi_eff;
                    lo_q    <= lo_eff;
                    cnt_q   <= hi_eff - 8'd1;
                    state_q <= StHigh;
                end
                StHigh: begin
                    if (cnt_q == '0) begin
                        sync_q  <= 1'b0;
                        cnt_q   <= lo_q - 8'd1;
                        state_q <= StLow;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StLow: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else if (rpt_q != '0) begin
                        rpt_q   <= rpt_q - 16'd1;
                        cnt_q   <= hi_q - 8'd1;
                        state_q <= StHigh;
                    end else if (last_q) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else if (stop_req) begin
                        state_q <= StIdle;
                    end else if (!fifo_empty) begin
                        wft_q   <= head_wft;
                        wfc_q   <= head_wfc;
                        rpt_q   <= head_rpt;
                        last_q  <= head_last;
                        state_q <= StLoad;
                    end else begin
                        underrun_q <= 1'b1;
                        state_q    <= StStall;
                    end
                end
                StStall: begin
                    if (stop_req) begin
                        state_q <= StIdle;
                    end else if (!fifo_empty) begin
                        wft_q   <= head_wft;
                        wfc_q   <= head_wfc;
                        rpt_q   <= head_rpt;
                        last_q  <= head_last;
                        state_q <= StLoad;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef PVS_SIGNATURE_EN
    localparam int unsigned SigW    = WFT_W + WfcBits;
    localparam int unsigned SigPadW = ((SigW + 15) / 16) * 16;

    logic [SigPadW-1:0] sig_word;
    logic [15:0]        sig_fold, sig_q;

    // Zero padding sits at the LSB end of the folded word.
    always_comb begin
        sig_word = SigPadW'({wft_q, wfc_q}) << (SigPadW - SigW);
        sig_fold = '0;
        for (int i = 0; i < int'(SigPadW / 16); i++) sig_fold ^= sig_word[16*i +: 16];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            sig_q <= '0;
        end else if (enter_high) begin
            sig_q <= {sig_q[14:0], sig_q[15]} ^ sig_fold;
        end
    end

    assign signature = sig_q;
`endif

    assign tester_sync = sync_q;
    assign wft         = wft_q;
    assign wfc         = wfc_q;
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign underrun    = underrun_q;
    assign vec_count   = count_q;
endmodule
